ame_num_descale: RTL and testbench
==================================

# ame_num_descale

Restores the magnitude of the two numerator-side operands {M, L} after they were arithmetically right-shifted by the AME operand scaler. It accepts one pair of scaled signed results plus the shift amount the scaler reported. It applies an arithmetic left shift of that amount, at most STEP_BITS positions per cycle, and saturates on overflow. It sits after the affine-parameter solver in the AME datapath and uses the same init/done pulse convention as the scaler, plus a ready output because it is multi-cycle.

## Interface
- COMP_DATA_BITS, 64, operand width (signed, two's complement)
- STEP_BITS, 16, maximum left-shift applied per cycle; power of two, ≤ COMP_DATA_BITS
- clk_i  input  1  clock, all logic on rising edge
- rst_n_i  input  1  asynchronous active-low reset
- comp_init_i  input  1  start pulse; accepted only when comp_ready_o=1
- comp_ready_o  output  1  block idle and able to accept comp_init_i
- comp_done_o  output  1  one-cycle pulse: comp_data_o/comp_ovf_o updated
- comp_shift_i  input  $clog2(COMP_DATA_BITS)  left-shift amount (0..63)
- comp_data_i  input  [1:0][COMP_DATA_BITS]  {M, L}, signed
- comp_data_o  output  [1:0][COMP_DATA_BITS]  restored {M, L}
- comp_ovf_o  output  [1:0]  per-lane saturation flag for the last result

## Operation
- States: IDLE, SHIFT, DONE. comp_ready_o = (state==IDLE), decoded from registered state.
- IDLE + comp_init_i: latch comp_data_i into the work registers, comp_shift_i into rem, and clear the per-lane sat flags. Next state is DONE if comp_shift_i==0, else SHIFT.
- comp_init_i outside IDLE is ignored; inputs are sampled only at the accept edge.
- SHIFT, each cycle: k = min(rem, STEP_BITS); each lane without sat shifts left by k; rem -= k; go to DONE when the new rem==0.
- Overflow rule per lane per step: if the top k+1 bits of the work value are not all equal, set sat for that lane. The work value becomes 2^(N-1)-1 if the original sign was 0, else -2^(N-1). A saturated lane is not shifted again.
- DONE (one cycle): register the work values into comp_data_o and sat into comp_ovf_o, pulse comp_done_o, then return to IDLE.
- comp_data_o and comp_ovf_o hold their value until the next DONE.
- Lanes are independent; one lane saturating does not affect the other.

## Timing
- Reset values: state IDLE; comp_ready_o=1; comp_done_o=0; comp_data_o=0; comp_ovf_o=0; work registers and rem = 0.
- Accept edge is cycle 0. comp_done_o is high in cycle 1+ceil(s/STEP_BITS), where s = comp_shift_i.
- With STEP_BITS=16: s=0 gives 1, s=1..16 gives 2, s=63 gives 5.
- comp_ready_o goes low in the cycle after accept. It returns high in the cycle after the comp_done_o cycle.
- Throughput: one operation per 2+ceil(s/STEP_BITS) cycles. There is no back-to-back accept in the DONE cycle.
- rst_n_i asserted mid-operation: all state and outputs return to reset values immediately. No comp_done_o is produced for the aborted operation.
- Output data, comp_ovf_o and comp_done_o are all registered; no combinational input→output paths.

## Test plan
- Reset, then idle: comp_ready_o=1, comp_done_o=0, comp_data_o=0, comp_ovf_o=0. Assert init with s=0, M=-7, L=0x1234 → done at cycle 1, comp_data_o={-7, 0x1234}, ovf=00.
- s=20, M=0x1234, L=-3 → done at cycle 3, M=0x1_2340_0000, L=-3145728, ovf=00.
- Boundary s=63: M=-1, L=1 → done at cycle 5. M=0x8000_0000_0000_0000 with ovf[1]=0; L=0x7FFF_FFFF_FFFF_FFFF with ovf[0]=1.
- s=62: M=1 → 0x4000_0000_0000_0000, no ovf. Same shift with M=2 → 0x7FFF…F, ovf[1]=1, overflow detected in the final step.
- comp_init_i held high for the whole operation with changing comp_data_i → exactly one done per accept. The result uses the values at the accept edge; the next accept happens only after ready returns.
- rst_n_i pulsed during SHIFT with s=40 → outputs return to reset values, no done pulse. A following s=0 operation completes normally at cycle 1.

Source files
------------

// File: rtl/ame_num_descale.sv
// Restores the magnitude of the scaled {M, L} pair by an arithmetic left shift of
// up to STEP_BITS positions per cycle, saturating each lane independently on overflow.
module ame_num_descale #(
    parameter int COMP_DATA_BITS = 64,
    parameter int STEP_BITS      = 16,
    localparam int SHW           = $clog2(COMP_DATA_BITS)
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           comp_init_i,
    output logic                           comp_ready_o,
    output logic                           comp_done_o,
    input  logic [SHW-1:0]                 comp_shift_i,
    input  logic [1:0][COMP_DATA_BITS-1:0] comp_data_i,
    output logic [1:0][COMP_DATA_BITS-1:0] comp_data_o,
    output logic [1:0]                     comp_ovf_o
);

    localparam logic [SHW:0] STEP_K = (SHW + 1)'(STEP_BITS);
    localparam logic [COMP_DATA_BITS-1:0] SAT_POS = {1'b0, {(COMP_DATA_BITS - 1) {1'b1}}};
    localparam logic [COMP_DATA_BITS-1:0] SAT_NEG = {1'b1, {(COMP_DATA_BITS - 1) {1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [1:0][COMP_DATA_BITS-1:0]   work_q, work_d;
    logic [1:0][COMP_DATA_BITS-1:0]   shl, shr;
    logic [1:0]                       sat_q, sat_d;
    logic [1:0]                       step_ovf;
    logic [SHW-1:0]                   rem_q, rem_d;
    logic [SHW:0]                     k;

    assign comp_ready_o = (state_q == IDLE);

    // A step of k is lossless only if shifting back by k reproduces the value,
    // i.e. the top k+1 bits are all copies of the sign.
    always_comb begin
        k = ({1'b0, rem_q} > STEP_K) ? STEP_K : {1'b0, rem_q};
        shl = '0;
        shr = '0;
        step_ovf = '0;
        for (int i = 0; i < 2; i++) begin
            shl[i]      = work_q[i] << k;
            shr[i]      = $signed(shl[i]) >>> k;
            step_ovf[i] = (shr[i] != work_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        sat_d   = sat_q;
        unique case (state_q)
            IDLE: begin
                if (comp_init_i) begin
                    work_d  = comp_data_i;
                    rem_d   = comp_shift_i;
                    sat_d   = '0;
                    state_d = (comp_shift_i == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                for (int i = 0; i < 2; i++) begin
                    if (!sat_q[i]) begin
                        if (step_ovf[i]) begin
                            sat_d[i]  = 1'b1;
                            work_d[i] = work_q[i][COMP_DATA_BITS-1] ? SAT_NEG : SAT_POS;
                        end else begin
                            work_d[i] = shl[i];
                        end
                    end
                end
                rem_d = rem_q - k[SHW-1:0];
                if (rem_d == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            sat_q   <= sat_d;
        end
    end

    // Outputs load on the edge entering DONE, so the done pulse and the new
    // result are visible exactly during the DONE cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            comp_done_o <= 1'b0;
            comp_data_o <= '0;
            comp_ovf_o  <= '0;
        end else begin
            comp_done_o <= (state_d == DONE);
            if (state_d == DONE) begin
                comp_data_o <= work_d;
                comp_ovf_o  <= sat_d;
            end
        end
    end

endmodule

// File: tb/tb_ame_num_descale.sv
// Scoreboard bench for ame_num_descale: driver pushes expected results at accept,
// a negedge monitor pops and compares on every comp_done_o.
module tb_ame_num_descale;

    localparam int N  = 64;
    localparam int NV = 12;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           init = 1'b0;
    logic           ready;
    logic           done;
    logic [5:0]     shift = '0;
    logic [1:0][N-1:0] din = '0;
    logic [1:0][N-1:0] dout;
    logic [1:0]     ovf;

    ame_num_descale #(.COMP_DATA_BITS(N), .STEP_BITS(16)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .comp_init_i  (init),
        .comp_ready_o (ready),
        .comp_done_o  (done),
        .comp_shift_i (shift),
        .comp_data_i  (din),
        .comp_data_o  (dout),
        .comp_ovf_o   (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [N-1:0] m;
        logic [N-1:0] l;
        logic [1:0]   ovf;
        int           lat;
        int           acc;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    logic [5:0]   v_s[NV];
    logic [N-1:0] v_m[NV], v_l[NV], e_m[NV], e_l[NV];
    logic [1:0]   e_o[NV];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic set_vec(input int i, input logic [5:0] s, input logic [N-1:0] m,
                           input logic [N-1:0] l, input logic [N-1:0] em,
                           input logic [N-1:0] el, input logic [1:0] eo);
        v_s[i] = s; v_m[i] = m; v_l[i] = l;
        e_m[i] = em; e_l[i] = el; e_o[i] = eo;
    endtask

    // init stays high across the whole range; inputs are scrambled while busy
    task automatic run_ops(input int first, input int last);
        exp_t e;
        int   n;
        for (int i = first; i <= last; i++) begin
            n = 0;
            while (!ready && n < 200) begin
                din   = {$urandom, $urandom, $urandom, $urandom};
                shift = 6'($urandom_range(0, 63));
                @(negedge clk);
                n++;
            end
            if (!ready) begin
                check("ready_timeout", 64'(ready), 64'd1);
                init = 1'b0;
                return;
            end
            din   = {v_m[i], v_l[i]};
            shift = v_s[i];
            init  = 1'b1;
            e.m   = e_m[i];
            e.l   = e_l[i];
            e.ovf = e_o[i];
            e.lat = 1 + (int'(v_s[i]) + 15) / 16;
            e.acc = cyc + 1;
            exp_q.push_back(e);
            @(negedge clk);
        end
        init = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("data_m", dout[1], e.m);
                check("data_l", dout[0], e.l);
                check("ovf", 64'(ovf), 64'(e.ovf));
                check("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end
    end

    initial begin
        set_vec(0, 6'd0, -64'sd7, 64'h1234, -64'sd7, 64'h1234, 2'b00);
        set_vec(1, 6'd20, 64'h1234, -64'sd3, 64'h0000_0001_2340_0000, -64'sd3145728, 2'b00);
        set_vec(2, 6'd63, -64'sd1, 64'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 2'b01);
        set_vec(3, 6'd62, 64'd1, 64'd0, 64'h4000_0000_0000_0000, 64'd0, 2'b00);
        set_vec(4, 6'd62, 64'd2, -64'sd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hC000_0000_0000_0000, 2'b10);
        set_vec(5, 6'd16, 64'h0000_8000_0000_0000, -64'sd32768, 64'h7FFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_8000_0000, 2'b10);
        set_vec(6, 6'd1, 64'hC000_0000_0000_0000, 64'h4000_0000_0000_0000,
                64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 2'b01);
        set_vec(7, 6'd33, 64'd3, -64'sd5, 64'h0000_0006_0000_0000, 64'hFFFF_FFF6_0000_0000, 2'b00);
        set_vec(8, 6'd4, 64'h8000_0000_0000_0001, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 2'b10);
        set_vec(9, 6'd5, 64'd1, -64'sd1, 64'd32, -64'sd32, 2'b00);
        set_vec(10, 6'd0, 64'd100, -64'sd100, 64'd100, -64'sd100, 2'b00);
        set_vec(11, 6'd48, -64'sd1, 64'h7FFF, 64'hFFFF_0000_0000_0000, 64'h7FFF_0000_0000_0000, 2'b00);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", dout[1] | dout[0], 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);

        for (int i = 0; i <= 8; i++) run_ops(i, i);
        run_ops(9, 11);

        // abort an s=40 operation while it is shifting
        while (!ready) @(negedge clk);
        din   = {64'd5, 64'd9};
        shift = 6'd40;
        init  = 1'b1;
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_done", 64'(done), 64'd0);
        check("abort_data", dout[1] | dout[0], 64'd0);
        check("abort_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run_ops(0, 0);

        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("pending_results", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
